seq_stage_sequencer: RTL
========================

SEQ_STAGE_SEQUENCER -- requirements
Module: seq_stage_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 8, max cycles MEMORY waits for mem_ack before declaring ADR (range 1..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin execution; sampled only in IDLE.
REQ-005 icode  input  4  fetched instruction code, valid from DECODE onward.
REQ-006 hlt, instr_valid, imem_error  input  1 each  fetch status flags, valid in DECODE.
REQ-007 mem_ack  input  1  data-memory access complete; dmem_error  input  1  access faulted, qualified by mem_ack.
REQ-008 fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en  output  1 each  one-hot stage enables.
REQ-009 mem_req  output  1  data-memory request, held until acknowledged.
REQ-010 stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-011 busy  output  1  high in every state except IDLE and HALTED.
REQ-012 cycle_count  output  32  cycles spent busy; instr_count  output  32  instructions retired.

Function
REQ-013 States SHALL be IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED (plus PAUSE per REQ-030).
REQ-014 Exactly one stage enable SHALL be high in FETCH..PCUPD, matching the state; all enables low in IDLE, HALTED, PAUSE.
REQ-015 IDLE -> FETCH when start=1; otherwise remain in IDLE.
REQ-016 FETCH -> DECODE unconditionally after one cycle.
REQ-017 On the edge leaving DECODE, flags SHALL be checked with priority imem_error > !instr_valid > hlt: imem_error -> stat=3, HALTED; !instr_valid -> stat=4, HALTED; hlt -> stat=2, HALTED; otherwise -> EXECUTE.
REQ-018 EXECUTE -> MEMORY unconditionally.
REQ-019 In MEMORY, mem_req SHALL be high only when icode is 4, 5, 8, 9, 0xA, or 0xB; for other icodes, MEMORY SHALL last exactly one cycle.
REQ-020 mem_ack=1 with dmem_error=0 -> WRITEBACK; mem_ack=1 with dmem_error=1 -> stat=3, HALTED, and writeback is skipped.
REQ-021 The wait counter SHALL clear on entering MEMORY; if it reaches MEM_TIMEOUT cycles without mem_ack -> stat=3, HALTED, mem_req dropped.
REQ-022 mem_ack SHALL be ignored outside MEMORY, and when mem_req is low.
REQ-023 WRITEBACK -> PCUPD; PCUPD -> FETCH, with instr_count incremented on that edge.
REQ-024 Nominal latency SHALL be 6 cycles per instruction (mem_ack in the first MEMORY cycle, or a non-memory icode); each extra wait cycle adds 1.
REQ-025 cycle_count SHALL increment on every clock edge while busy=1, saturating at 0xFFFF_FFFF; instr_count SHALL saturate likewise.
REQ-026 HALTED SHALL be terminal; start is ignored; outputs hold until reset.
REQ-027 stat SHALL be 1 from reset until an error or halt is registered.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, all enables and mem_req low, stat=1, both counters 0, and the wait counter 0, including mid-instruction or mid-MEMORY-wait.
REQ-029 If rst_n deasserts on the same edge that start=1, start is ignored; a start on a later edge is required.

Configuration
REQ-030 With SINGLE_STEP_EN defined: add input step (1 bit); PCUPD SHALL go to PAUSE, and PAUSE -> FETCH on step=1 (busy stays high; cycle_count does not increment in PAUSE).
REQ-031 Without SINGLE_STEP_EN: no step port and no PAUSE state; PCUPD -> FETCH directly.

Verification
REQ-032 Reset, start=1 for one cycle, icode=6, flags clean, three instructions -> enables cycle FETCH..PCUPD; instr_count=3 and cycle_count=18 after 18 busy cycles.
REQ-033 icode=5, mem_ack asserted on the 3rd MEMORY cycle -> mem_req high for 3 cycles; instruction takes 8 cycles; stat stays 1.
REQ-034 imem_error=1 and hlt=1 together in DECODE -> stat=3, HALTED, busy=0, and execute_en never asserted.
REQ-035 icode=4, MEM_TIMEOUT=8, mem_ack never asserted -> after 8 MEMORY cycles stat=3, HALTED, writeback_en never asserted.
REQ-036 rst_n pulled low during a MEMORY wait, then start -> IDLE, counters 0, stat=1, and a clean restart from FETCH.
REQ-037 SINGLE_STEP_EN defined: after PCUPD, state held in PAUSE for 5 cycles until step=1 -> FETCH; cycle_count unchanged during PAUSE.

Source files
------------

// File: rtl/seq_stage_sequencer.sv
// Multi-cycle Y86-style stage sequencer: FETCH..PCUPD one-hot enables, memory handshake with timeout, status and counters.
// Optional single-step PAUSE state enabled by defining SINGLE_STEP_EN (adds input i_step).
module seq_stage_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [3:0]  i_icode,
   input  logic        i_hlt,
   input  logic        i_instr_valid,
   input  logic        i_imem_error,
   input  logic        i_mem_ack,
   input  logic        i_dmem_error,
`ifdef SINGLE_STEP_EN
   input  logic        i_step,
`endif
   output logic        o_fetch_en,
   output logic        o_decode_en,
   output logic        o_execute_en,
   output logic        o_memory_en,
   output logic        o_writeback_en,
   output logic        o_pc_en,
   output logic        o_mem_req,
   output logic [2:0]  o_stat,
   output logic        o_busy,
   output logic [31:0] o_cycle_count,
   output logic [31:0] o_instr_count
);

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

`ifdef SINGLE_STEP_EN
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALTED, S_PAUSE
   } state_t;
`else
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALTED
   } state_t;
`endif

   state_t      r_state;
   state_t      w_state_next;
   logic [2:0]  r_stat;
   logic [2:0]  w_stat_next;
   logic [7:0]  r_wait_cnt;
   logic [7:0]  w_wait_next;
   logic        r_armed;
   logic [31:0] r_cycle_count;
   logic [31:0] r_instr_count;
   logic        w_retire;
   logic        w_is_mem;
   logic        w_count_en;

   always_comb begin
      w_is_mem = 1'b0;
      case (i_icode)
         4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: w_is_mem = 1'b1;
         default:                            w_is_mem = 1'b0;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_stat_next  = r_stat;
      w_wait_next  = r_wait_cnt;
      w_retire     = 1'b0;
      case (r_state)
         // r_armed blocks a start that coincides with the first edge after reset release
         S_IDLE:    if (i_start && r_armed) w_state_next = S_FETCH;
         S_FETCH:   w_state_next = S_DECODE;
         S_DECODE: begin
            if (i_imem_error) begin
               w_state_next = S_HALTED;
               w_stat_next  = STAT_ADR;
            end else if (!i_instr_valid) begin
               w_state_next = S_HALTED;
               w_stat_next  = STAT_INS;
            end else if (i_hlt) begin
               w_state_next = S_HALTED;
               w_stat_next  = STAT_HLT;
            end else begin
               w_state_next = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            w_state_next = S_MEMORY;
            w_wait_next  = 8'd0;
         end
         S_MEMORY: begin
            if (!w_is_mem) begin
               w_state_next = S_WRITEBACK;
            end else if (i_mem_ack) begin
               if (i_dmem_error) begin
                  w_state_next = S_HALTED;
                  w_stat_next  = STAT_ADR;
               end else begin
                  w_state_next = S_WRITEBACK;
               end
            end else if (r_wait_cnt == WAIT_LAST) begin
               w_state_next = S_HALTED;
               w_stat_next  = STAT_ADR;
            end else begin
               w_wait_next = r_wait_cnt + 8'd1;
            end
         end
         S_WRITEBACK: w_state_next = S_PCUPD;
         S_PCUPD: begin
            w_retire = 1'b1;
`ifdef SINGLE_STEP_EN
            w_state_next = S_PAUSE;
`else
            w_state_next = S_FETCH;
`endif
         end
`ifdef SINGLE_STEP_EN
         S_PAUSE:   if (i_step) w_state_next = S_FETCH;
`endif
         S_HALTED:  w_state_next = S_HALTED;
         default:   w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_stat        <= STAT_AOK;
         r_wait_cnt    <= 8'd0;
         r_armed       <= 1'b0;
         r_cycle_count <= 32'd0;
         r_instr_count <= 32'd0;
      end else begin
         r_state    <= w_state_next;
         r_stat     <= w_stat_next;
         r_wait_cnt <= w_wait_next;
         r_armed    <= 1'b1;
         if (w_count_en && (r_cycle_count != 32'hFFFF_FFFF))
            r_cycle_count <= r_cycle_count + 32'd1;
         if (w_retire && (r_instr_count != 32'hFFFF_FFFF))
            r_instr_count <= r_instr_count + 32'd1;
      end
   end

   assign o_fetch_en     = (r_state == S_FETCH);
   assign o_decode_en    = (r_state == S_DECODE);
   assign o_execute_en   = (r_state == S_EXECUTE);
   assign o_memory_en    = (r_state == S_MEMORY);
   assign o_writeback_en = (r_state == S_WRITEBACK);
   assign o_pc_en        = (r_state == S_PCUPD);
   assign o_mem_req      = (r_state == S_MEMORY) && w_is_mem;
   assign o_busy         = (r_state != S_IDLE) && (r_state != S_HALTED);
`ifdef SINGLE_STEP_EN
   assign w_count_en     = o_busy && (r_state != S_PAUSE);
`else
   assign w_count_en     = o_busy;
`endif
   assign o_stat         = r_stat;
   assign o_cycle_count  = r_cycle_count;
   assign o_instr_count  = r_instr_count;

endmodule
